// File: rtl/pixel_vector_packer_if.sv
// Stream bundle for pixel_vector_packer: a pixel-in stream and a packed-vector-out stream.
// The slave modport is the packer; the master modport is the source/sink around it.
interface pixel_vector_packer_if #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 30,
    parameter int CNT_W         = 16
);
    // Both streams use valid/ready: a beat transfers on a rising clk edge where
    // valid & ready are both 1; a source holding valid keeps its data stable until it transfers.
    logic [XLEN_PIXEL-1:0]               pix_in;
    logic                                pix_valid;
    logic                                pix_last;
    logic                                pix_ready;
    logic [NUM_OF_PIXELS*XLEN_PIXEL-1:0] vec_out;
    logic                                vec_valid;
    logic                                vec_ready;
    logic                                vec_short;
    logic [CNT_W-1:0]                    vec_count;

    modport slave (
        input  pix_in, pix_valid, pix_last, vec_ready,
        output pix_ready, vec_out, vec_valid, vec_short, vec_count
    );

    modport master (
        output pix_in, pix_valid, pix_last, vec_ready,
        input  pix_ready, vec_out, vec_valid, vec_short, vec_count
    );
endinterface

// File: rtl/pixel_vector_packer.sv
// Packs a serial pixel stream into NUM_OF_PIXELS-wide vectors through a two-entry
// ping-pong buffer so filling continues while the vector consumer stalls.
module pixel_vector_packer #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 30,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pixel_vector_packer_if.slave bus
);
    localparam int VW    = XLEN_PIXEL * NUM_OF_PIXELS;
    localparam int IDX_W = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OF_PIXELS - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       occ_q, occ_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic [VW-1:0]    buf_q [2];
    logic [VW-1:0]    buf_d [2];
    logic [1:0]       short_q, short_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic pix_ready;
    logic vec_valid;
    logic accept;
    logic close;
    logic pop;

    assign pix_ready = (occ_q != 2'd2);
    assign vec_valid = (occ_q != 2'd0);
    assign accept    = bus.pix_valid & pix_ready;
    assign close     = accept & ((idx_q == LAST_IDX) | bus.pix_last);
    assign pop       = vec_valid & bus.vec_ready;

    always_comb begin
        idx_d   = idx_q;
        occ_d   = occ_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        buf_d   = buf_q;
        short_d = short_q;
        cnt_d   = cnt_q;

        if (accept) begin
            // Pixel 0 of a fill wipes the slot so an early close leaves zeros above it.
            if (idx_q == '0) begin
                buf_d[wr_q] = '0;
            end
            for (int k = 0; k < NUM_OF_PIXELS; k++) begin
                if (IDX_W'(k) == idx_q) begin
                    buf_d[wr_q][k*XLEN_PIXEL +: XLEN_PIXEL] = bus.pix_in;
                end
            end
            if (close) begin
                short_d[wr_q] = (idx_q != LAST_IDX);
                wr_d          = ~wr_q;
                idx_d         = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (pop) begin
            rd_d  = ~rd_q;
            cnt_d = cnt_q + 1'b1;
        end

        case ({close, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q    <= '0;
            occ_q    <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            short_q  <= '0;
            cnt_q    <= '0;
        end else begin
            idx_q    <= idx_d;
            occ_q    <= occ_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
            short_q  <= short_d;
            cnt_q    <= cnt_d;
        end
    end

    // A drained slot is masked so vec_out reads zero whenever nothing is offered.
    assign bus.pix_ready = pix_ready;
    assign bus.vec_valid = vec_valid;
    assign bus.vec_out   = vec_valid ? buf_q[rd_q] : '0;
    assign bus.vec_short = vec_valid & short_q[rd_q];
    assign bus.vec_count = cnt_q;
endmodule
